shift_add_mult_seq: RTL and testbench
=====================================

Name: shift_add_mult_seq

Overview:
- Parametrised N-bit sequential shift-add multiplier. It is the next generation of the team's fixed 8-bit shift-add multiplier.
- Adds:
  - signed/unsigned mode selected per operation,
  - a valid/ready handshake on both input and output,
  - a synchronous abort.
- Computes one product per N-cycle iteration run and holds the 2N-bit result until it is consumed.
- Sits between the operand-issue logic and the result consumer in the datapath.

Parameters:
- N, 8, operand width in bits; legal range 2..32.
- CW, $clog2(N), width of the iteration counter (derived; not overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- abort  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  N  multiplicand.
- b  input  N  multiplier.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts result.
- result  output  2N  product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - ACC, Q, M, count, mode register, result = 0.
  - out_valid = 0, busy = 0, in_ready = 1 after release.
- Internal registers:
  - ACC, N+1 bits.
  - Q, N bits (multiplier, shifted out LSB-first).
  - M, N bits.
  - mode_s, 1 bit.
  - count, CW bits.
- FSM state IDLE:
  - in_ready = 1.
  - On in_valid at a clock edge:
    - M = a, Q = b, ACC = 0, mode_s = is_signed, count = 0.
    - Go to CALC.
- FSM state CALC, one iteration per cycle:
  - ext(M) is sign-extended to N+1 bits if mode_s = 1, zero-extended if mode_s = 0.
  - If Q[0] = 0: sum = ACC.
  - If Q[0] = 1 and NOT (mode_s and count = N-1): sum = ACC + ext(M).
  - If Q[0] = 1 and mode_s and count = N-1: sum = ACC - ext(M). This is the signed MSB weight correction.
  - Shift for signed mode: ACC = {sum[N], sum[N:1]}.
  - Shift for unsigned mode: ACC = {1'b0, sum[N:1]}.
  - Q = {sum[0], Q[N-1:1]}.
  - count increments each iteration.
  - When count = N-1, the same edge also:
    - registers result = {ACC_next[N-1:0], Q_next},
    - moves the FSM to DONE.
- FSM state DONE:
  - out_valid = 1; result is stable.
  - On out_ready: go to IDLE and clear out_valid at that edge.
  - Without out_ready: hold indefinitely.
- Latency:
  - Operand accept edge to out_valid high is exactly N cycles.
  - Minimum issue interval is N+2 cycles. in_ready is low in DONE, so there is no accept in the same cycle as result consumption.
- result:
  - Retains the last product after leaving DONE, until the next DONE load.
  - Valid only while out_valid = 1.
- Arithmetic and width:
  - Width is exact; no overflow is possible.
  - Unsigned range is 0..(2^N-1)^2.
  - Signed range includes (-2^(N-1))^2 = 2^(2N-2).
- Boundary conditions:
  - in_valid while busy: ignored (in_ready = 0); operands are not sampled.
  - abort: highest priority synchronous event in any state.
    - Go to IDLE, out_valid = 0, count = 0.
    - result is held; a pending DONE result is discarded.
  - abort and in_valid in the same IDLE cycle: abort wins; no accept.
  - rst asserted mid-CALC or in DONE: immediate return to reset values; no partial result is emitted.
  - a = 0 or b = 0: still takes N cycles; result = 0.
  - is_signed changing during CALC: no effect; mode_s is latched at accept.

Decomposition:
- Package shift_add_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE),
  - the function computing CW from N.
- Sub-module mult_step (combinational) is natural. It takes ACC, Q, M, mode_s and is_last, and produces ACC_next and Q_next.
- The top module holds the FSM, counter and handshake.

Test Plan:
- N=8, unsigned, a=255, b=255, out_ready=1 → out_valid exactly 8 cycles after accept, result=16'hFE01 (65025).
- N=8, signed:
  - a=-128 (8'h80), b=-128 → result=16'h4000.
  - a=-3 (8'hFD), b=5 → result=16'hFFF1.
  - a=7, b=-1 → result=16'hFFF9.
- N=8, unsigned, a=12, b=10, out_ready=0 for 20 cycles → out_valid and result=16'h0078 held stable; in_ready=0 throughout; in_valid pulses with a=1, b=1 are ignored. Then out_ready=1 → in_ready=1 next cycle.
- Mid-CALC disruptions, N=8, a=200, b=3:
  - Assert rst low at cycle 4 of CALC → all outputs at reset values immediately, in_ready=1 after release.
  - Same stimulus, abort at cycle 4 → IDLE next edge, out_valid never rises.
  - A fresh 9*9 issued afterwards yields 81.
- N=4, unsigned 15*15 → 8'hE1 in 4 cycles; N=4, signed -8*-8 → 8'h40.
- N=16, randomised 1000 signed and unsigned pairs, back-to-back issue → every result matches the reference product; issue interval is exactly 18 cycles.

Source files
------------

// File: rtl/shift_add_mult_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_pkg
// Brief    : FSM state encoding and counter-width helper for shift_add_mult_seq
// Revision : 1.0
// ============================================================================
package shift_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest width able to count iterations 0..n-1.
    function automatic int calc_cw(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_mult_seq_mult_step.sv
`default_nettype none
// ============================================================================
// Module   : mult_step
// Brief    : One combinational shift-add iteration (add/subtract, then shift)
// Revision : 1.0
// ============================================================================
module mult_step #(
    parameter int N = 8
) (
    input  logic [N:0]   acc,
    input  logic [N-1:0] q,
    input  logic [N-1:0] m,
    input  logic         mode_s,
    input  logic         is_last,
    output logic [N:0]   acc_next,
    output logic [N-1:0] q_next
);

    logic [N:0] m_ext;
    logic [N:0] sum;

    always_comb begin
        m_ext = {mode_s & m[N-1], m};
        // In signed mode the multiplier MSB carries negative weight.
        if (!q[0]) begin
            sum = acc;
        end else if (mode_s && is_last) begin
            sum = acc - m_ext;
        end else begin
            sum = acc + m_ext;
        end
        acc_next = {mode_s & sum[N], sum[N:1]};
        q_next   = {sum[0], q[N-1:1]};
    end

endmodule
`default_nettype wire

// File: rtl/shift_add_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_seq
// Brief    : N-bit sequential signed/unsigned shift-add multiplier, valid/ready
// Revision : 1.0
// ============================================================================
module shift_add_mult_seq
    import shift_add_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           abort,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
    output logic           busy
);

    localparam int            CW   = calc_cw(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state;
    logic [N:0]     acc;
    logic [N-1:0]   q;
    logic [N-1:0]   m;
    logic           mode_s;
    logic [CW-1:0]  count;

    logic [N:0]     acc_next;
    logic [N-1:0]   q_next;
    logic           is_last;

    assign is_last = (count == LAST);

    mult_step #(.N(N)) u_step (
        .acc      (acc),
        .q        (q),
        .m        (m),
        .mode_s   (mode_s),
        .is_last  (is_last),
        .acc_next (acc_next),
        .q_next   (q_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            mode_s    <= 1'b0;
            count     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else if (abort) begin
            // result is deliberately left untouched
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m        <= a;
                        q        <= b;
                        acc      <= '0;
                        mode_s   <= is_signed;
                        count    <= '0;
                        state    <= CALC;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    q   <= q_next;
                    if (is_last) begin
                        count     <= '0;
                        result    <= {acc_next[N-1:0], q_next};
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mult_seq
// Brief    : Scoreboard bench for N=4, 8 and 16 instances of shift_add_mult_seq
// Revision : 1.0
// ============================================================================
module tb_shift_add_mult_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- N = 8 ----------------
    logic        ab8 = 0, iv8 = 0, sg8 = 0, or8 = 1;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        rdy8, ov8, bz8;
    logic [15:0] res8;
    shift_add_mult_seq #(.N(8)) u8 (
        .clk(clk), .rst(rst), .abort(ab8), .in_valid(iv8), .in_ready(rdy8),
        .a(a8), .b(b8), .is_signed(sg8), .out_valid(ov8), .out_ready(or8),
        .result(res8), .busy(bz8));

    // ---------------- N = 4 ----------------
    logic        ab4 = 0, iv4 = 0, sg4 = 0, or4 = 1;
    logic [3:0]  a4 = 0, b4 = 0;
    logic        rdy4, ov4, bz4;
    logic [7:0]  res4;
    shift_add_mult_seq #(.N(4)) u4 (
        .clk(clk), .rst(rst), .abort(ab4), .in_valid(iv4), .in_ready(rdy4),
        .a(a4), .b(b4), .is_signed(sg4), .out_valid(ov4), .out_ready(or4),
        .result(res4), .busy(bz4));

    // ---------------- N = 16 ----------------
    logic        ab16 = 0, iv16 = 0, sg16 = 0, or16 = 1;
    logic [15:0] a16 = 0, b16 = 0;
    logic        rdy16, ov16, bz16;
    logic [31:0] res16;
    shift_add_mult_seq #(.N(16)) u16 (
        .clk(clk), .rst(rst), .abort(ab16), .in_valid(iv16), .in_ready(rdy16),
        .a(a16), .b(b16), .is_signed(sg16), .out_valid(ov16), .out_ready(or16),
        .result(res16), .busy(bz16));

    longint q8[$], q4[$], q16[$];
    int acc_cyc8, acc_cyc4, acc_cyc16;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Mathematical product of the operands, truncated to 2n bits.
    function automatic longint ref_prod(input int n, input longint av, input longint bv, input bit s);
        longint x, y, p;
        x = av;
        y = bv;
        if (s) begin
            if (x >= (64'sd1 << (n - 1))) x = x - (64'sd1 << n);
            if (y >= (64'sd1 << (n - 1))) y = y - (64'sd1 << n);
        end
        p = x * y;
        return p & ((64'sd1 << (2 * n)) - 1);
    endfunction

    // Monitors: compare every consumed result against the scoreboard head.
    always @(negedge clk) begin
        if (ov8 && or8) begin
            if (q8.size() == 0) check("unexpected_out8", 64'(res8), 64'hFFFF_FFFF_FFFF_FFFF);
            else check("result8", 64'(res8), 64'(q8.pop_front()));
        end
        if (ov4 && or4) begin
            if (q4.size() == 0) check("unexpected_out4", 64'(res4), 64'hFFFF_FFFF_FFFF_FFFF);
            else check("result4", 64'(res4), 64'(q4.pop_front()));
        end
        if (ov16 && or16) begin
            if (q16.size() == 0) check("unexpected_out16", 64'(res16), 64'hFFFF_FFFF_FFFF_FFFF);
            else check("result16", 64'(res16), 64'(q16.pop_front()));
        end
    end

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic s, input bit push);
        @(posedge clk); #1;
        a8 = av; b8 = bv; sg8 = s; iv8 = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy8) break;
        end
        if (!rdy8) begin
            check("accept8_timeout", 64'(rdy8), 64'd1);
            iv8 = 0;
            return;
        end
        if (push) q8.push_back(ref_prod(8, longint'(av), longint'(bv), s));
        @(posedge clk); #1;
        acc_cyc8 = cyc;
        iv8 = 0;
    endtask

    task automatic issue4(input logic [3:0] av, input logic [3:0] bv, input logic s);
        @(posedge clk); #1;
        a4 = av; b4 = bv; sg4 = s; iv4 = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy4) break;
        end
        if (!rdy4) begin
            check("accept4_timeout", 64'(rdy4), 64'd1);
            iv4 = 0;
            return;
        end
        q4.push_back(ref_prod(4, longint'(av), longint'(bv), s));
        @(posedge clk); #1;
        acc_cyc4 = cyc;
        iv4 = 0;
    endtask

    // Leaves in_valid high so consecutive calls issue back-to-back.
    task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic s);
        @(posedge clk); #1;
        a16 = av; b16 = bv; sg16 = s; iv16 = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy16) break;
        end
        if (!rdy16) begin
            check("accept16_timeout", 64'(rdy16), 64'd1);
            return;
        end
        q16.push_back(ref_prod(16, longint'(av), longint'(bv), s));
        @(posedge clk); #1;
        acc_cyc16 = cyc;
    endtask

    // Cycles from the accept edge until out_valid is seen high.
    task automatic wait_ov8(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ov8) begin lat = k; break; end
        end
    endtask

    task automatic wait_ov4(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ov4) begin lat = k; break; end
        end
    endtask

    initial begin
        int lat;
        int prev;
        logic [15:0] ra, rb;
        logic rs;
        bit  seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(ov8), 64'd0);
        check("rst_busy", 64'(bz8), 64'd0);
        check("rst_result", 64'(res8), 64'd0);
        rst = 1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(rdy8), 64'd1);

        // Unsigned 255*255, latency N
        or8 = 1;
        issue8(8'd255, 8'd255, 1'b0, 1);
        wait_ov8(lat);
        check("latency8", 64'(lat), 64'd8);
        check("result8_fe01", 64'(res8), 64'hFE01);
        @(posedge clk); #1;

        // Signed cases
        issue8(8'h80, 8'h80, 1'b1, 1);
        wait_ov8(lat);
        check("result8_4000", 64'(res8), 64'h4000);
        issue8(8'hFD, 8'd5, 1'b1, 1);
        wait_ov8(lat);
        issue8(8'd7, 8'hFF, 1'b1, 1);
        wait_ov8(lat);
        @(posedge clk); #1;

        // Hold in DONE with consumer stalled; new operands ignored
        or8 = 0;
        issue8(8'd12, 8'd10, 1'b0, 1);
        wait_ov8(lat);
        check("hold_latency8", 64'(lat), 64'd8);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("hold_ov", 64'(ov8), 64'd1);
            check("hold_res", 64'(res8), 64'h0078);
            check("hold_in_ready", 64'(rdy8), 64'd0);
            @(posedge clk); #1;
            a8 = 8'd1; b8 = 8'd1; iv8 = (k % 2 == 0);
        end
        iv8 = 0;
        or8 = 1;
        @(posedge clk); #1;
        check("consume_in_ready", 64'(rdy8), 64'd1);
        check("consume_ov", 64'(ov8), 64'd0);
        check("retain_result", 64'(res8), 64'h0078);

        // Abort at cycle 4 of CALC
        issue8(8'd200, 8'd3, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        ab8 = 1;
        @(posedge clk); #1;
        ab8 = 0;
        check("abort_busy", 64'(bz8), 64'd0);
        check("abort_in_ready", 64'(rdy8), 64'd1);
        check("abort_result_held", 64'(res8), 64'h0078);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ov8) seen = 1;
        end
        check("abort_no_out", 64'(seen), 64'd0);

        // Abort beats in_valid in IDLE
        a8 = 8'd5; b8 = 8'd5; iv8 = 1; ab8 = 1;
        @(posedge clk); #1;
        iv8 = 0; ab8 = 0;
        check("abort_vs_valid_busy", 64'(bz8), 64'd0);
        check("abort_vs_valid_rdy", 64'(rdy8), 64'd1);

        // Reset mid-CALC
        issue8(8'd200, 8'd3, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        #1;
        check("midrst_busy", 64'(bz8), 64'd0);
        check("midrst_ov", 64'(ov8), 64'd0);
        check("midrst_result", 64'(res8), 64'd0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        check("midrst_in_ready", 64'(rdy8), 64'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ov8) seen = 1;
        end
        check("midrst_no_out", 64'(seen), 64'd0);

        // Fresh 9*9 and zero operand
        issue8(8'd9, 8'd9, 1'b0, 1);
        wait_ov8(lat);
        check("result8_81", 64'(res8), 64'd81);
        issue8(8'd0, 8'd77, 1'b1, 1);
        wait_ov8(lat);
        check("zero_latency8", 64'(lat), 64'd8);

        // N = 4
        issue4(4'd15, 4'd15, 1'b0);
        wait_ov4(lat);
        check("latency4", 64'(lat), 64'd4);
        check("result4_e1", 64'(res4), 64'hE1);
        issue4(4'h8, 4'h8, 1'b1);
        wait_ov4(lat);
        check("result4_40", 64'(res4), 64'h40);

        // N = 16 randomized back-to-back
        or16 = 1;
        prev = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rs = 1'($urandom_range(0, 1));
            if (i % 97 == 5)  ra = 16'h0;
            if (i % 89 == 7)  rb = 16'h8000;
            if (i % 83 == 11) begin ra = 16'h8000; rb = 16'h8000; end
            issue16(ra, rb, rs);
            if (i > 0) check("interval16", 64'(acc_cyc16 - prev), 64'd18);
            prev = acc_cyc16;
        end
        iv16 = 0;

        // Drain scoreboards
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (q8.size() == 0 && q4.size() == 0 && q16.size() == 0) break;
        end
        check("drain8", 64'(q8.size()), 64'd0);
        check("drain4", 64'(q4.size()), 64'd0);
        check("drain16", 64'(q16.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
